router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx.sv | 184 ++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one packet payload from an upstream byte stream, then
// sends header {len,dest}, the payload bytes and a trailing parity byte to the
// router, honouring the router's busy back-pressure.
// Optional feature: define PKT_TX_ERR_INJ_EN to let inj_err (sampled with
// start) invert the transmitted parity byte of that packet.
module router_pkt_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       done,
    output logic       req_err,
    input  logic       inj_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        HEADER  = 3'd2,
        PAYLOAD = 3'd3,
        PARITY  = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Fold one byte into the running parity accumulator.
    function automatic logic [7:0] parity_acc(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    // Parity byte as transmitted, optionally inverted for fault injection.
    function automatic logic [7:0] parity_out(input logic [7:0] par, input logic inj);
        return inj ? (par ^ 8'hFF) : par;
    endfunction

    state_t      state_r;
    logic [1:0]  dest_r;
    logic [5:0]  len_r;
    logic [5:0]  idx_r;
    logic [7:0]  parity_r;
    logic        ready_r;
    logic        pl_ready_r;
    logic        pkt_valid_r;
    logic [7:0]  data_out_r;
    logic        done_r;
    logic        req_err_r;
    logic [7:0]  buf_r [0:63];
    logic        inj_sel_s;
    logic        load_fire_s;

    assign load_fire_s = pl_ready_r & pl_valid;

`ifdef PKT_TX_ERR_INJ_EN
    logic inj_r;

    // Capture the per-packet parity corruption request when a start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_r <= 1'b0;
        end else if (ready_r && start && (len != 6'd0) && (dest != 2'b11)) begin
            inj_r <= inj_err;
        end
    end

    assign inj_sel_s = inj_r;
`else
    logic inj_unused_s;

    assign inj_unused_s = inj_err;
    assign inj_sel_s    = 1'b0;
`endif

    // Payload buffer; contents are don't-care after reset, so it has none.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            buf_r[idx_r] <= pl_data;
        end
    end

    // Packet sequencer with all handshake outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            dest_r      <= 2'b00;
            len_r       <= 6'd0;
            idx_r       <= 6'd0;
            parity_r    <= 8'h00;
            ready_r     <= 1'b1;
            pl_ready_r  <= 1'b0;
            pkt_valid_r <= 1'b0;
            data_out_r  <= 8'h00;
            done_r      <= 1'b0;
            req_err_r   <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            req_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if ((len == 6'd0) || (dest == 2'b11)) begin
                            req_err_r <= 1'b1;
                        end else begin
                            dest_r     <= dest;
                            len_r      <= len;
                            idx_r      <= 6'd0;
                            parity_r   <= {len, dest};
                            ready_r    <= 1'b0;
                            pl_ready_r <= 1'b1;
                            state_r    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (pl_valid) begin
                        parity_r <= parity_acc(parity_r, pl_data);
                        if (idx_r == (len_r - 6'd1)) begin
                            idx_r       <= 6'd0;
                            pl_ready_r  <= 1'b0;
                            pkt_valid_r <= 1'b1;
                            data_out_r  <= {len_r, dest_r};
                            state_r     <= HEADER;
                        end else begin
                            idx_r <= idx_r + 6'd1;
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        idx_r      <= 6'd0;
                        data_out_r <= buf_r[6'd0];
                        state_r    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        if (idx_r == (len_r - 6'd1)) begin
                            idx_r       <= 6'd0;
                            pkt_valid_r <= 1'b0;
                            data_out_r  <= parity_out(parity_r, inj_sel_s);
                            state_r     <= PARITY;
                        end else begin
                            idx_r      <= idx_r + 6'd1;
                            data_out_r <= buf_r[idx_r + 6'd1];
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        data_out_r <= 8'h00;
                        done_r     <= 1'b1;
                        state_r    <= DONE;
                    end
                end
                DONE: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    idx_r       <= 6'd0;
                    ready_r     <= 1'b1;
                    pl_ready_r  <= 1'b0;
                    pkt_valid_r <= 1'b0;
                    data_out_r  <= 8'h00;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_r;
    assign pl_ready  = pl_ready_r;
    assign pkt_valid = pkt_valid_r;
    assign data_out  = data_out_r;
    assign done      = done_r;
    assign req_err   = req_err_r;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx.
module tb_router_pkt_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       ready;
    logic       done;
    logic       req_err;
    logic       inj_err;

    int checks = 0;
    int errors = 0;

    router_pkt_tx dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dest      (dest),
        .len       (len),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .ready     (ready),
        .done      (done),
        .req_err   (req_err),
        .inj_err   (inj_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue_start(input logic [1:0] d, input logic [5:0] l, input logic inj);
        start = 1'b1; dest = d; len = l; inj_err = inj;
        tick();
        start = 1'b0; inj_err = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        pl_valid = 1'b1; pl_data = b;
        tick();
        pl_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dest = 2'b00; len = 6'd0; pl_data = 8'h00;
        pl_valid = 1'b0; busy = 1'b0; inj_err = 1'b0;
        tick(); tick();
        checks++;
        if ({ready, pl_ready, pkt_valid, data_out, done, req_err} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", {ready, pl_ready, pkt_valid, data_out, done, req_err}, 13'b1_0_0_00000000_0_0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({ready, pkt_valid, data_out, done} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", {ready, pkt_valid, data_out, done}, 11'b1_0_00000000_0);
        end
    endtask

    task automatic test_basic();
        logic [7:0] pay [3];
        logic [7:0] par;
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        par = 8'h0C ^ 8'h11 ^ 8'h22 ^ 8'h33;
        issue_start(2'd0, 6'd3, 1'b0);
        checks++;
        if ({ready, pl_ready, pkt_valid} !== 3'b010) begin
            errors++; $display("FAIL basic_load_entry got %b exp 010", {ready, pl_ready, pkt_valid});
        end
        // start while busy loading, even an illegal one, must be ignored
        start = 1'b1; dest = 2'b11; len = 6'd0;
        feed(pay[0]);
        start = 1'b0;
        checks++;
        if ({req_err, pkt_valid, pl_ready} !== 3'b001) begin
            errors++; $display("FAIL basic_start_ignored got %b exp 001", {req_err, pkt_valid, pl_ready});
        end
        feed(pay[1]);
        feed(pay[2]);
        checks++;
        if ({pkt_valid, pl_ready, data_out} !== {1'b1, 1'b0, 8'h0C}) begin
            errors++; $display("FAIL basic_header got %h exp %h", {pkt_valid, pl_ready, data_out}, {1'b1, 1'b0, 8'h0C});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({pkt_valid, data_out} !== {1'b1, pay[i]}) begin
                errors++; $display("FAIL basic_payload%0d got %h exp %h", i, {pkt_valid, data_out}, {1'b1, pay[i]});
            end
        end
        tick();
        checks++;
        if ({pkt_valid, data_out, done} !== {1'b0, par, 1'b0}) begin
            errors++; $display("FAIL basic_parity got %h exp %h", {pkt_valid, data_out, done}, {1'b0, par, 1'b0});
        end
        tick();
        checks++;
        if ({done, ready, pkt_valid, data_out} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL basic_done got %h exp %h", {done, ready, pkt_valid, data_out}, 11'h400);
        end
        tick();
        checks++;
        if ({done, ready} !== 2'b01) begin
            errors++; $display("FAIL basic_idle got %b exp 01", {done, ready});
        end
    endtask

    task automatic test_busy_hold();
        issue_start(2'd1, 6'd2, 1'b0);
        feed(8'hA5);
        feed(8'h5A);
        checks++;
        if ({pkt_valid, data_out} !== {1'b1, 8'h09}) begin
            errors++; $display("FAIL busy_header got %h exp %h", {pkt_valid, data_out}, 9'h109);
        end
        tick();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({pkt_valid, data_out} !== {1'b1, 8'hA5}) begin
                errors++; $display("FAIL busy_hold%0d got %h exp %h", i, {pkt_valid, data_out}, 9'h1A5);
            end
            tick();
        end
        checks++;
        if ({pkt_valid, data_out} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL busy_hold_last got %h exp %h", {pkt_valid, data_out}, 9'h1A5);
        end
        busy = 1'b0;
        tick();
        checks++;
        if ({pkt_valid, data_out} !== {1'b1, 8'h5A}) begin
            errors++; $display("FAIL busy_resume got %h exp %h", {pkt_valid, data_out}, 9'h15A);
        end
        tick();
        checks++;
        if ({pkt_valid, data_out} !== {1'b0, 8'hF6}) begin
            errors++; $display("FAIL busy_parity got %h exp %h", {pkt_valid, data_out}, 9'h0F6);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL busy_done got %b exp 1", done);
        end
        tick();
    endtask

    task automatic test_reject();
        start = 1'b1; dest = 2'd0; len = 6'd0;
        tick();
        start = 1'b0;
        checks++;
        if ({req_err, ready, pkt_valid, pl_ready} !== 4'b1100) begin
            errors++; $display("FAIL reject_len0 got %b exp 1100", {req_err, ready, pkt_valid, pl_ready});
        end
        tick();
        checks++;
        if ({req_err, ready} !== 2'b01) begin
            errors++; $display("FAIL reject_len0_pulse got %b exp 01", {req_err, ready});
        end
        start = 1'b1; dest = 2'd3; len = 6'd5;
        tick();
        start = 1'b0;
        checks++;
        if ({req_err, ready, pkt_valid, pl_ready} !== 4'b1100) begin
            errors++; $display("FAIL reject_dest3 got %b exp 1100", {req_err, ready, pkt_valid, pl_ready});
        end
        tick();
        checks++;
        if ({req_err, ready, pkt_valid} !== 3'b010) begin
            errors++; $display("FAIL reject_dest3_pulse got %b exp 010", {req_err, ready, pkt_valid});
        end
    endtask

    task automatic test_gaps();
        logic [7:0] pay [3];
        pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h40;
        issue_start(2'd2, 6'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({pkt_valid, pl_ready} !== 2'b01) begin
                errors++; $display("FAIL gaps_wait%0d got %b exp 01", i, {pkt_valid, pl_ready});
            end
            feed(pay[i]);
        end
        checks++;
        if ({pkt_valid, data_out} !== {1'b1, 8'h0E}) begin
            errors++; $display("FAIL gaps_header got %h exp %h", {pkt_valid, data_out}, 9'h10E);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({pkt_valid, data_out} !== {1'b1, pay[i]}) begin
                errors++; $display("FAIL gaps_payload%0d got %h exp %h", i, {pkt_valid, data_out}, {1'b1, pay[i]});
            end
        end
        tick();
        checks++;
        if ({pkt_valid, data_out} !== {1'b0, 8'h7E}) begin
            errors++; $display("FAIL gaps_parity got %h exp %h", {pkt_valid, data_out}, 9'h07E);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        issue_start(2'd1, 6'd2, 1'b0);
        feed(8'hC3);
        feed(8'h3C);
        tick();
        checks++;
        if ({pkt_valid, data_out} !== {1'b1, 8'hC3}) begin
            errors++; $display("FAIL rstmid_payload got %h exp %h", {pkt_valid, data_out}, 9'h1C3);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({pkt_valid, data_out, ready, pl_ready, done} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rstmid_immediate got %h exp %h", {pkt_valid, data_out, ready, pl_ready, done}, 12'h004);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({ready, pkt_valid, done} !== 3'b100) begin
            errors++; $display("FAIL rstmid_idle got %b exp 100", {ready, pkt_valid, done});
        end
        issue_start(2'd2, 6'd1, 1'b0);
        feed(8'h7E);
        checks++;
        if ({pkt_valid, data_out} !== {1'b1, 8'h06}) begin
            errors++; $display("FAIL rstmid_header got %h exp %h", {pkt_valid, data_out}, 9'h106);
        end
        tick();
        checks++;
        if ({pkt_valid, data_out} !== {1'b1, 8'h7E}) begin
            errors++; $display("FAIL rstmid_payload2 got %h exp %h", {pkt_valid, data_out}, 9'h17E);
        end
        tick();
        checks++;
        if ({pkt_valid, data_out} !== {1'b0, 8'h78}) begin
            errors++; $display("FAIL rstmid_parity got %h exp %h", {pkt_valid, data_out}, 9'h078);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL rstmid_done got %b exp 1", done);
        end
        tick();
    endtask

    task automatic test_inj();
        logic [7:0] exp_par;
`ifdef PKT_TX_ERR_INJ_EN
        exp_par = 8'hFB;
`else
        exp_par = 8'h04;
`endif
        issue_start(2'd0, 6'd1, 1'b1);
        feed(8'h00);
        checks++;
        if ({pkt_valid, data_out} !== {1'b1, 8'h04}) begin
            errors++; $display("FAIL inj_header got %h exp %h", {pkt_valid, data_out}, 9'h104);
        end
        tick();
        checks++;
        if ({pkt_valid, data_out} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL inj_payload got %h exp %h", {pkt_valid, data_out}, 9'h100);
        end
        tick();
        checks++;
        if ({pkt_valid, data_out} !== {1'b0, exp_par}) begin
            errors++; $display("FAIL inj_parity got %h exp %h", {pkt_valid, data_out}, {1'b0, exp_par});
        end
        tick();
        tick();
        checks++;
        if ({ready, done} !== 2'b10) begin
            errors++; $display("FAIL inj_idle got %b exp 10", {ready, done});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_hold();
        test_reject();
        test_gaps();
        test_reset_mid();
        test_inj();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
